pc_fetch_sequencer: RTL and testbench

// - Owns the program counter and sequences instruction fetch for the MIPS core.
// - Chooses next PC from sequential, branch, jump or jump-register, and forms the jump

---
 rtl/pc_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the program counter of the MIPS core and sequences instruction fetch.
// It sits between instruction memory and the IF/ID stage.
//
// Fetch protocol:
//   - Instruction memory side: single-outstanding req/ack. imem_req is held,
//     with imem_addr stable, until imem_ack returns the instruction word.
//   - Decode side: valid/ready. A fetched word is held on if_* until decode
//     accepts it with if_valid && if_ready.
//
// Next-PC selection:
//   - Sequential pc + 4.
//   - Redirects, in priority order jr_en > jmp_en > br_taken. Only the
//     highest-priority redirect is used.
//
// Parameters:
//   RESET_PC    - PC loaded on reset; this is the first address fetched.
//   ALIGN_CHECK - 1: a jr target with nonzero [1:0] sets the sticky misalign
//                 flag. 0: misalign stays 0.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   imem_req/addr     fetch request and its address (outputs)
//   imem_ack/rdata    request completion and the instruction word (inputs)
//   if_valid/ready    handshake to decode
//   if_instr/pc/pc_plus4
//                     fetched word, its address, and that address + 4
//   br_*, jmp_*, jr_* redirect requests and their operands
//   misalign          sticky flag: a jr target was not word aligned
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // decode
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  // redirects
  input  logic        br_taken,
  input  logic [31:0] br_pc_plus4,
  input  logic [31:0] br_offset,
  input  logic        jmp_en,
  input  logic [31:0] jmp_pc_plus4,
  input  logic [25:0] jmp_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  // status
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Branch target: pc+4 of the branch plus the word offset scaled to bytes.
  // Wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] offset);
    return pc_plus4 + (offset << 2);
  endfunction

  // Jump target: the upper nibble comes from the jump's own pc+4, not from
  // the fetch PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  // Register jump target with the byte offset bits forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  state_t      state_r;
  state_t      state_next_s;

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic        req_r;
  logic        req_next_s;
  logic        valid_r;
  logic        valid_next_s;
  logic [31:0] instr_r;
  logic [31:0] instr_next_s;
  logic [31:0] if_pc_r;
  logic [31:0] if_pc_next_s;
  logic [31:0] if_pc_plus4_r;
  logic [31:0] if_pc_plus4_next_s;
  logic        misalign_r;
  logic        misalign_next_s;

  logic        redirect_s;
  logic [31:0] redirect_target_s;
  logic        jr_misaligned_s;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s      = pc_r + 32'd4;
  assign redirect_s      = jr_en | jmp_en | br_taken;
  assign jr_misaligned_s = ALIGN_CHECK && jr_en && (jr_addr[1:0] != 2'b00);

  // Redirect target selection: jr beats jump, jump beats branch.
  always_comb begin
    redirect_target_s = pc_r;
    if (jr_en) begin
      redirect_target_s = word_align(jr_addr);
    end else if (jmp_en) begin
      redirect_target_s = jump_target(jmp_pc_plus4, jmp_target);
    end else if (br_taken) begin
      redirect_target_s = branch_target(br_pc_plus4, br_offset);
    end else begin
      redirect_target_s = pc_r;
    end
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_next_s       = state_r;
    pc_next_s          = pc_r;
    req_next_s         = req_r;
    valid_next_s       = valid_r;
    instr_next_s       = instr_r;
    if_pc_next_s       = if_pc_r;
    if_pc_plus4_next_s = if_pc_plus4_r;
    misalign_next_s    = misalign_r;

    if (redirect_s) begin
      // A redirect wins in every state. A word returning on the same edge
      // is dropped. A word held for decode is squashed; if decode accepts
      // it on this edge, decode handles the ordering.
      state_next_s = ST_REQ;
      pc_next_s    = redirect_target_s;
      req_next_s   = 1'b1;
      valid_next_s = 1'b0;
      if (jr_misaligned_s) begin
        misalign_next_s = 1'b1;
      end else begin
        misalign_next_s = misalign_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_REQ;
          req_next_s   = 1'b1;
        end
        ST_REQ: begin
          if (imem_ack) begin
            state_next_s       = ST_HOLD;
            req_next_s         = 1'b0;
            valid_next_s       = 1'b1;
            instr_next_s       = imem_rdata;
            if_pc_next_s       = pc_r;
            if_pc_plus4_next_s = pc_plus4_s;
            pc_next_s          = pc_plus4_s;
          end else begin
            state_next_s = ST_REQ;
          end
        end
        ST_HOLD: begin
          // if_valid is always 1 here, so if_ready alone completes the transfer.
          if (if_ready) begin
            state_next_s = ST_REQ;
            req_next_s   = 1'b1;
            valid_next_s = 1'b0;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          req_next_s   = 1'b0;
          valid_next_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC and output registers. Reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      req_r         <= 1'b0;
      valid_r       <= 1'b0;
      instr_r       <= 32'h0000_0000;
      if_pc_r       <= 32'h0000_0000;
      if_pc_plus4_r <= 32'h0000_0000;
      misalign_r    <= 1'b0;
    end else begin
      pc_r          <= pc_next_s;
      req_r         <= req_next_s;
      valid_r       <= valid_next_s;
      instr_r       <= instr_next_s;
      if_pc_r       <= if_pc_next_s;
      if_pc_plus4_r <= if_pc_plus4_next_s;
      misalign_r    <= misalign_next_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign if_valid    = valid_r;
  assign if_instr    = instr_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;
  assign misalign    = misalign_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer. Redirect cases come from a table of
// {inputs, expected address}; multi-cycle corner cases are written out by hand.
// Inputs are driven on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        br_taken;
  logic [31:0] br_pc_plus4;
  logic [31:0] br_offset;
  logic        jmp_en;
  logic [31:0] jmp_pc_plus4;
  logic [25:0] jmp_target;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        misalign;

  int n_checks;
  int n_fail;

  pc_fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .ALIGN_CHECK (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .br_taken     (br_taken),
    .br_pc_plus4  (br_pc_plus4),
    .br_offset    (br_offset),
    .jmp_en       (jmp_en),
    .jmp_pc_plus4 (jmp_pc_plus4),
    .jmp_target   (jmp_target),
    .jr_en        (jr_en),
    .jr_addr      (jr_addr),
    .misalign     (misalign)
  );

  typedef struct {
    string       name;
    logic        jr_en;
    logic        jmp_en;
    logic        br_taken;
    logic [31:0] br_pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jmp_pc_plus4;
    logic [25:0] jmp_target;
    logic [31:0] jr_addr;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs [6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clear_redirects();
    br_taken     = 1'b0;
    br_pc_plus4  = 32'h0000_0000;
    br_offset    = 32'h0000_0000;
    jmp_en       = 1'b0;
    jmp_pc_plus4 = 32'h0000_0000;
    jmp_target   = 26'h000_0000;
    jr_en        = 1'b0;
    jr_addr      = 32'h0000_0000;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    if_ready   = 1'b0;
    clear_redirects();

    //                name          jr    jmp   br    br_pc4        br_off        jmp_pc4       jmp_tgt        jr_addr       expected
    vecs[0] = '{"jmp",        1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA000_0010, 26'h000_0100, 32'h0000_0000, 32'hA000_0400};
    vecs[1] = '{"br_back",    1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFE, 32'h0000_0000, 26'h000_0000, 32'h0000_0000, 32'h0000_00F8};
    vecs[2] = '{"jmp_vs_br",  1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFE, 32'hA000_0010, 26'h000_0100, 32'h0000_0000, 32'hA000_0400};
    vecs[3] = '{"jr_wins",    1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFE, 32'hA000_0010, 26'h000_0100, 32'h0000_2000, 32'h0000_2000};
    vecs[4] = '{"br_wrap",    1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0008, 32'h0000_0000, 26'h000_0000, 32'h0000_0000, 32'h0000_0010};
    vecs[5] = '{"jmp_top",    1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hF000_0000, 26'h3FF_FFFF, 32'h0000_0000, 32'hFFFF_FFFC};

    // Reset values.
    @(negedge clk);
    tick();
    chk("rst_req",      {31'd0, imem_req}, 32'd0);
    chk("rst_addr",     imem_addr,          32'h0000_0000);
    chk("rst_valid",    {31'd0, if_valid}, 32'd0);
    chk("rst_instr",    if_instr,           32'h0000_0000);
    chk("rst_if_pc",    if_pc,              32'h0000_0000);
    chk("rst_pc_plus4", if_pc_plus4,        32'h0000_0000);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    // Release reset: one IDLE cycle, then the request rises.
    rst_n = 1'b1;
    chk("idle_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    chk("req_rises", {31'd0, imem_req}, 32'd1);

    // Sequential fetch 0, 4, 8, C with immediate ack and ready.
    for (int i = 0; i < 4; i++) begin
      chk("seq_req",  {31'd0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr,          32'(i * 4));
      imem_ack   = 1'b1;
      imem_rdata = 32'hC0DE_0000 + 32'(i);
      tick();
      imem_ack = 1'b0;
      chk("seq_valid",  {31'd0, if_valid}, 32'd1);
      chk("seq_instr",  if_instr,           32'hC0DE_0000 + 32'(i));
      chk("seq_if_pc",  if_pc,              32'(i * 4));
      chk("seq_pc4",    if_pc_plus4,        32'(i * 4 + 4));
      chk("seq_req_lo", {31'd0, imem_req}, 32'd0);
      if_ready = 1'b1;
      tick();
      if_ready = 1'b0;
      chk("seq_accept", {31'd0, if_valid}, 32'd0);
    end

    // Decode stalls 5 cycles in HOLD: outputs frozen, no new request.
    chk("stall_addr", imem_addr, 32'h0000_0010);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_instr", if_instr,           32'h1234_5678);
      chk("stall_if_pc", if_pc,              32'h0000_0010);
      chk("stall_req",   {31'd0, imem_req}, 32'd0);
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("stall_next_req",  {31'd0, imem_req}, 32'd1);
    chk("stall_next_addr", imem_addr,          32'h0000_0014);

    // Redirect table, each vector applied while waiting in REQ.
    for (int v = 0; v < 6; v++) begin
      jr_en        = vecs[v].jr_en;
      jmp_en       = vecs[v].jmp_en;
      br_taken     = vecs[v].br_taken;
      br_pc_plus4  = vecs[v].br_pc_plus4;
      br_offset    = vecs[v].br_offset;
      jmp_pc_plus4 = vecs[v].jmp_pc_plus4;
      jmp_target   = vecs[v].jmp_target;
      jr_addr      = vecs[v].jr_addr;
      tick();
      clear_redirects();
      chk({vecs[v].name, "_addr"},     imem_addr,          vecs[v].exp_addr);
      chk({vecs[v].name, "_req"},      {31'd0, imem_req}, 32'd1);
      chk({vecs[v].name, "_valid"},    {31'd0, if_valid}, 32'd0);
      chk({vecs[v].name, "_misalign"}, {31'd0, misalign}, 32'd0);
    end

    // pc + 4 wraps from FFFF_FFFC to 0.
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_5555;
    tick();
    imem_ack = 1'b0;
    chk("wrap_if_pc", if_pc,       32'hFFFF_FFFC);
    chk("wrap_pc4",   if_pc_plus4, 32'h0000_0000);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Ack together with a branch: the word is dropped, the branch target is fetched.
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    br_taken    = 1'b1;
    br_pc_plus4 = 32'h0000_0100;
    br_offset   = 32'hFFFF_FFFE;
    tick();
    imem_ack = 1'b0;
    clear_redirects();
    chk("ackbr_valid", {31'd0, if_valid}, 32'd0);
    chk("ackbr_req",   {31'd0, imem_req}, 32'd1);
    chk("ackbr_addr",  imem_addr,          32'h0000_00F8);
    tick();
    chk("ackbr_valid2", {31'd0, if_valid}, 32'd0);
    chk("ackbr_addr2",  imem_addr,          32'h0000_00F8);

    // Redirect in HOLD while decode accepts: squash and fetch the jump target.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    tick();
    imem_ack = 1'b0;
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    if_ready     = 1'b1;
    jmp_en       = 1'b1;
    jmp_pc_plus4 = 32'hA000_0010;
    jmp_target   = 26'h000_0100;
    tick();
    if_ready = 1'b0;
    clear_redirects();
    chk("holdjmp_valid", {31'd0, if_valid}, 32'd0);
    chk("holdjmp_addr",  imem_addr,          32'hA000_0400);
    chk("holdjmp_req",   {31'd0, imem_req}, 32'd1);

    // Misaligned jr: target aligned, misalign sticky.
    jr_en   = 1'b1;
    jr_addr = 32'h0000_1003;
    tick();
    clear_redirects();
    chk("jr_mis_addr", imem_addr,          32'h0000_1000);
    chk("jr_mis_flag", {31'd0, misalign}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("jr_mis_hold", {31'd0, misalign}, 32'd1);
    end

    // Reset during REQ, then a stray ack in IDLE is ignored.
    rst_n = 1'b0;
    tick();
    chk("mrst_req",      {31'd0, imem_req}, 32'd0);
    chk("mrst_addr",     imem_addr,          32'h0000_0000);
    chk("mrst_valid",    {31'd0, if_valid}, 32'd0);
    chk("mrst_instr",    if_instr,           32'h0000_0000);
    chk("mrst_if_pc",    if_pc,              32'h0000_0000);
    chk("mrst_pc4",      if_pc_plus4,        32'h0000_0000);
    chk("mrst_misalign", {31'd0, misalign}, 32'd0);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    tick();
    imem_ack = 1'b0;
    chk("stray_valid", {31'd0, if_valid}, 32'd0);
    chk("stray_instr", if_instr,           32'h0000_0000);
    chk("stray_req",   {31'd0, imem_req}, 32'd1);
    chk("stray_addr",  imem_addr,          32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
